// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// ready/read handshake with sticky overrun and one-cycle framing-error pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       serial_in_i,
    input  logic       read_i,
    output logic [7:0] data_o,
    output logic       byte_ready_o,
    output logic       framing_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t          state_r;
    logic [1:0]      sync_r;
    logic            rx_s;
    logic [CW-1:0]   baud_r;
    logic [2:0]      bit_r;
    logic [7:0]      shift_r;
    logic [7:0]      data_r;
    logic            ready_r;
    logic            ferr_r;
    logic            ovr_r;
    logic            busy_r;

    assign rx_s          = sync_r[1];
    assign data_o        = data_r;
    assign byte_ready_o  = ready_r;
    assign framing_err_o = ferr_r;
    assign overrun_o     = ovr_r;
    assign busy_o        = busy_r;

    // Two-flop synchronizer on the asynchronous line, idling high.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], serial_in_i};
        end
    end

    // Receive FSM, baud/bit counters, shift register and host-side outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r <= IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            ready_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ferr_r <= 1'b0;
            // A host read consumes the byte; a stop-bit load below may override it.
            if (read_i && ready_r) begin
                ready_r <= 1'b0;
                ovr_r   <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    baud_r <= BAUD_ZERO;
                    bit_r  <= 3'd0;
                    if (!rx_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_r == HALF_LAST) begin
                        baud_r <= BAUD_ZERO;
                        if (!rx_s) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_r == BIT_LAST) begin
                        baud_r  <= BAUD_ZERO;
                        shift_r <= {rx_s, shift_r[7:1]};
                        bit_r   <= bit_r + 3'd1;
                        if (bit_r == 3'd7) begin
                            state_r <= STOP;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_r == BIT_LAST) begin
                        baud_r <= BAUD_ZERO;
                        if (rx_s) begin
                            data_r  <= shift_r;
                            ready_r <= 1'b1;
                            ovr_r   <= ready_r && !read_i;
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            ferr_r  <= 1'b1;
                            state_r <= BREAK;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                BREAK: begin
                    baud_r <= BAUD_ZERO;
                    if (rx_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    baud_r  <= BAUD_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven on the serial pin, expected bytes
// kept in a scoreboard queue and compared when the receiver reports them.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NS = 160;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       serial_in_i = 1'b1;
    logic       read_i = 1'b0;
    logic [7:0] data_o;
    logic       byte_ready_o;
    logic       framing_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;
    int busy_count = 0;
    bit tx_active = 1'b0;
    logic [7:0] sb[$];

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .serial_in_i  (serial_in_i),
        .read_i       (read_i),
        .data_o       (data_o),
        .byte_ready_o (byte_ready_o),
        .framing_err_o(framing_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (framing_err_o) fe_count++;
        if (busy_o) busy_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Must be called at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns, input bit expect_it);
        tx_active = 1'b1;
        if (expect_it) sb.push_back(b);
        serial_in_i = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            serial_in_i = b[i];
            #(bit_ns);
        end
        serial_in_i = stop;
        #(bit_ns);
        tx_active = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (byte_ready_o !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd1);
    endtask

    task automatic check_data(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, data_o);
        end else begin
            e = sb.pop_front();
            check(tag, {24'd0, data_o}, {24'd0, e});
        end
    endtask

    task automatic read_byte();
        @(negedge clk);
        read_i = 1'b1;
        @(negedge clk);
        read_i = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        @(negedge clk);
        wait (!tx_active);
        @(negedge clk);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int fe0;
        int bc0;
        logic [7:0] held;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_o}, 32'h00);
        check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
        check("rst_ferr", {31'd0, framing_err_o}, 32'd0);
        check("rst_ovr", {31'd0, overrun_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        reset_i = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame A5 with exact latency from the pin edge
        fe0 = fe_count;
        fork
            send_frame(8'hA5, 1'b1, BIT_NS, 1'b1);
        join_none
        repeat (2) @(negedge clk);
        check("a5_busy_pre", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        check("a5_busy_on", {31'd0, busy_o}, 32'd1);
        repeat (151) @(negedge clk);
        check("a5_ready_early", {31'd0, byte_ready_o}, 32'd0);
        @(negedge clk);
        check("a5_ready_on_time", {31'd0, byte_ready_o}, 32'd1);
        check_data("a5_data");
        check("a5_ovr", {31'd0, overrun_o}, 32'd0);
        idle_gap(4);
        check("a5_ferr_count", fe_count - fe0, 32'd0);
        read_byte();
        check("a5_read_clears", {31'd0, byte_ready_o}, 32'd0);
        idle_gap(4);

        // Back-to-back frames with a read after each
        fe0 = fe_count;
        fork
            begin
                send_frame(8'h00, 1'b1, BIT_NS, 1'b1);
                send_frame(8'hFF, 1'b1, BIT_NS, 1'b1);
                send_frame(8'h55, 1'b1, BIT_NS, 1'b1);
            end
        join_none
        for (int k = 0; k < 3; k++) begin
            wait_ready($sformatf("b2b%0d", k));
            check_data($sformatf("b2b%0d_data", k));
            check($sformatf("b2b%0d_ovr", k), {31'd0, overrun_o}, 32'd0);
            read_byte();
        end
        idle_gap(4);
        check("b2b_ferr_count", fe_count - fe0, 32'd0);

        // Glitch shorter than half a bit
        fe0 = fe_count;
        bc0 = busy_count;
        serial_in_i = 1'b0;
        repeat (5) @(negedge clk);
        serial_in_i = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_bound", {31'd0, (busy_count - bc0) >= 1 && (busy_count - bc0) <= 8}, 32'd1);
        check("glitch_ready", {31'd0, byte_ready_o}, 32'd0);
        check("glitch_ferr_count", fe_count - fe0, 32'd0);
        check("glitch_busy_end", {31'd0, busy_o}, 32'd0);

        // Bad stop bit followed by a long break
        fe0 = fe_count;
        held = data_o;
        send_frame(8'h3C, 1'b0, BIT_NS, 1'b0);
        repeat (40 * 16) @(negedge clk);
        check("brk_busy_held", {31'd0, busy_o}, 32'd1);
        serial_in_i = 1'b1;
        repeat (20) @(negedge clk);
        check("brk_ferr_count", fe_count - fe0, 32'd1);
        check("brk_data_kept", {24'd0, data_o}, {24'd0, held});
        check("brk_ready_kept", {31'd0, byte_ready_o}, 32'd0);
        check("brk_busy_end", {31'd0, busy_o}, 32'd0);
        send_frame(8'h81, 1'b1, BIT_NS, 1'b1);
        wait_ready("after_brk");
        check_data("after_brk_data");
        read_byte();
        idle_gap(4);

        // Overrun: two frames without a read
        send_frame(8'h12, 1'b1, BIT_NS, 1'b1);
        send_frame(8'h34, 1'b1, BIT_NS, 1'b1);
        repeat (4) @(negedge clk);
        void'(sb.pop_front());
        check_data("ovr_data");
        check("ovr_flag", {31'd0, overrun_o}, 32'd1);
        check("ovr_ready", {31'd0, byte_ready_o}, 32'd1);
        read_byte();
        check("ovr_read_ready", {31'd0, byte_ready_o}, 32'd0);
        check("ovr_read_flag", {31'd0, overrun_o}, 32'd0);
        idle_gap(4);

        // Read on the exact cycle the second byte completes
        send_frame(8'h56, 1'b1, BIT_NS, 1'b1);
        repeat (4) @(negedge clk);
        check_data("sim_first_data");
        fork
            send_frame(8'h78, 1'b1, BIT_NS, 1'b1);
        join_none
        repeat (154) @(negedge clk);
        read_i = 1'b1;
        @(negedge clk);
        read_i = 1'b0;
        check("sim_ready", {31'd0, byte_ready_o}, 32'd1);
        check("sim_ovr", {31'd0, overrun_o}, 32'd0);
        check_data("sim_data");
        read_byte();
        idle_gap(4);

        // Reset pulse during data bit 4 (line high for the rest of the frame)
        fork
            send_frame(8'hF5, 1'b1, BIT_NS, 1'b0);
        join_none
        repeat (88) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        check("mrst_data", {24'd0, data_o}, 32'h00);
        check("mrst_ready", {31'd0, byte_ready_o}, 32'd0);
        check("mrst_busy", {31'd0, busy_o}, 32'd0);
        check("mrst_ovr", {31'd0, overrun_o}, 32'd0);
        idle_gap(10);
        check("mrst_no_byte", {31'd0, byte_ready_o}, 32'd0);
        send_frame(8'hC3, 1'b1, BIT_NS, 1'b1);
        wait_ready("mrst_c3");
        check_data("mrst_c3_data");
        read_byte();
        idle_gap(4);

        // Bit-period tolerance: slow and fast transmitters
        send_frame(8'hB7, 1'b1, 166, 1'b1);
        wait_ready("slow");
        check_data("slow_data");
        read_byte();
        idle_gap(4);
        send_frame(8'h4E, 1'b1, 156, 1'b1);
        serial_in_i = 1'b1;
        wait_ready("fast");
        check_data("fast_data");
        read_byte();
        idle_gap(4);
        check("final_ovr", {31'd0, overrun_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, idle-high line) from an asynchronous serial input and presents each byte to the host on a ready/read handshake. It is the far-end counterpart of the design's UART transmit path and must use the same bit period, so frames produced by the transmitter are received bit-exact. It flags framing errors and overruns.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; must equal the transmitter's bit period; legal range ≥ 4.
- HALF_BIT, default CLKS_PER_BIT/2 (integer division): cycles from start-edge detection to the mid-start sample.

Ports:
- clk_i, input, 1: single system clock; all logic rising-edge.
- reset_i, input, 1: synchronous, active-low reset.
- serial_in_i, input, 1: asynchronous serial line; idle = 1.
- read_i, input, 1: host acknowledges and consumes data_o this cycle.
- data_o, output, 8: last received byte; bit 0 = first data bit on the line.
- byte_ready_o, output, 1: data_o holds an unread byte.
- framing_err_o, output, 1: one-cycle pulse; stop bit sampled as 0.
- overrun_o, output, 1: sticky; a new byte arrived while the previous one was unread.
- busy_o, output, 1: high in any state other than IDLE.

## Operation
- Input synchronizer: two flops on serial_in_i. Both reset to 1. rx_s denotes the second flop's output; all FSM logic uses rx_s only.
- Baud counter: $clog2(CLKS_PER_BIT) bits, cleared on every state entry and after every sample. Bit counter: 3 bits, counts data bits 0..7.
- Shift register: shifts right, inserting rx_s at bit 7. After 8 samples, bit 0 holds the first data bit.
- FSM states:
  - IDLE: on rx_s==0, go to START and clear the baud counter.
  - START: when the baud counter reaches HALF_BIT-1, sample rx_s. If 0, go to DATA. If 1, treat as a glitch or false start: return to IDLE with no flag.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register. After the sample with bit counter == 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: load data_o from the shift register, set byte_ready_o, go to IDLE.
    - If 0: pulse framing_err_o, discard the byte (data_o and byte_ready_o unchanged), go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. A held-low line therefore produces exactly one framing error and no retriggered frames.
- Handshake:
  - read_i with byte_ready_o==1 clears byte_ready_o next cycle and clears overrun_o.
  - read_i while byte_ready_o==0 has no effect.
- Overrun: on a good stop bit while byte_ready_o==1 and read_i==0, overwrite data_o, keep byte_ready_o=1, set overrun_o.
- Simultaneous good stop and read_i: the new byte is loaded, byte_ready_o stays 1, overrun_o is cleared (not set).
- Reset mid-frame: the FSM returns to IDLE next edge and all partial state is discarded.

## Timing
- Reset values: data_o=8'h00, byte_ready_o=0, framing_err_o=0, overrun_o=0, busy_o=0. FSM=IDLE, counters=0, synchronizer=1.
- Let T0 be the clock edge at which IDLE sees rx_s==0 (2 cycles after the pin falls). Then:
  - Start sample at T0+HALF_BIT.
  - Data bit n (n=0..7) sampled at T0+HALF_BIT+(n+1)·CLKS_PER_BIT.
  - Stop sample at T0+HALF_BIT+9·CLKS_PER_BIT.
  - byte_ready_o, data_o and framing_err_o update on the edge after the stop sample.
- busy_o rises the cycle after T0 and falls with the return to IDLE.
- Back-to-back frames: a start bit immediately after the stop bit must be received. IDLE is re-entered at least HALF_BIT−1 cycles before the next start edge reaches rx_s.
- Tolerance: frames with a bit period within ±4% of CLKS_PER_BIT must be received correctly.

## Test plan
- Single frame (CLKS_PER_BIT=16), byte 8'hA5 → byte_ready_o=1 exactly 2+8+144+1 cycles after the start edge on the pin; data_o=8'hA5; framing_err_o and overrun_o stay 0.
- Back-to-back frames 8'h00, 8'hFF, 8'h55 with read_i pulsed after each → three ready events, data_o=00, FF, 55 in order, no errors.
- Glitch: line low for 5 cycles, then high → return to IDLE; busy_o high for at most 8 cycles; no byte_ready_o, no framing_err_o.
- Stop bit forced 0 on byte 8'h3C, line then held low for 40 bit periods → exactly one framing_err_o pulse; data_o and byte_ready_o unchanged; next good frame 8'h81 is received correctly.
- Two frames 8'h12, 8'h34 with no read_i → data_o=8'h34, overrun_o=1. Then read_i → byte_ready_o=0, overrun_o=0. Separately, read_i on the exact cycle the second byte completes → overrun_o stays 0.
- reset_i=0 for one cycle during data bit 4 of a frame → all outputs at reset values; the next complete frame 8'hC3 is received correctly.
